// File: rtl/picorv32_mem_arbiter.sv
// Two-master arbiter for the PicoRV32 native memory bus: one transaction at a time,
// registered request and response, bounded-timeout abort of a stalled slave access.
module picorv32_mem_arbiter #(
   parameter int          ARB_MODE       = 0,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'h0010_0073
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        m0_valid_i,
   input  logic        m0_instr_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   input  logic [3:0]  m0_wstrb_i,
   output logic        m0_ready_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_valid_i,
   input  logic        m1_instr_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   input  logic [3:0]  m1_wstrb_i,
   output logic        m1_ready_o,
   output logic [31:0] m1_rdata_o,
   output logic        s_valid_o,
   output logic        s_instr_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_wdata_o,
   output logic [3:0]  s_wstrb_o,
   input  logic        s_ready_i,
   input  logic [31:0] s_rdata_i,
   output logic        grant_o,
   output logic        busy_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic        RR_MODE = (ARB_MODE == 0);

   state_t      state, state_nxt;
   logic        last_grant;
   logic        winner;
   logic        done;
   logic        abort;
   logic [15:0] cnt;
   logic        timeout_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      winner    = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            // Round-robin ties go to whichever master did not own the last grant.
            if (m1_valid_i && (!m0_valid_i || (RR_MODE && !last_grant)))
               winner = 1'b1;
            if (m0_valid_i || m1_valid_i)
               state_nxt = REQ;
         end
         REQ: begin
            if (s_ready_i) begin
               done      = 1'b1;
               state_nxt = RESP;
            end else if (TO_EN && (cnt == TO_LAST)) begin
               abort     = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s_valid_o  <= 1'b0;
         s_instr_o  <= 1'b0;
         s_addr_o   <= '0;
         s_wdata_o  <= '0;
         s_wstrb_o  <= '0;
         grant_o    <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         m0_rdata_o <= '0;
         m1_rdata_o <= '0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= abort;
         case (state)
            IDLE: begin
               if (state_nxt == REQ) begin
                  s_valid_o  <= 1'b1;
                  grant_o    <= winner;
                  last_grant <= winner;
                  s_instr_o  <= winner ? m1_instr_i : m0_instr_i;
                  s_addr_o   <= winner ? m1_addr_i  : m0_addr_i;
                  s_wdata_o  <= winner ? m1_wdata_i : m0_wdata_i;
                  s_wstrb_o  <= winner ? m1_wstrb_i : m0_wstrb_i;
                  cnt        <= '0;
               end
            end
            REQ: begin
               if (done || abort) begin
                  s_valid_o <= 1'b0;
                  if (grant_o) m1_rdata_o <= done ? s_rdata_i : ERR_RDATA;
                  else         m0_rdata_o <= done ? s_rdata_i : ERR_RDATA;
               end else if (cnt != 16'hFFFF) begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign m0_ready_o = (state == RESP) && !grant_o;
   assign m1_ready_o = (state == RESP) &&  grant_o;
   assign busy_o     = (state != IDLE);
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: table of single transactions with a response scoreboard,
// plus reset-abort and continuous two-master sequences in both arbitration modes.
module tb_picorv32_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;

   logic        s_ready0 = 0, s_ready1 = 1;
   logic [31:0] s_rdata0 = 0, s_rdata1 = 32'h600D_0000;

   logic        m0_ready0, m1_ready0, s_valid0, s_instr0, grant0, busy0, timeout0;
   logic [31:0] m0_rdata0, m1_rdata0, s_addr0, s_wdata0;
   logic [3:0]  s_wstrb0;
   logic        m0_ready1, m1_ready1, s_valid1, s_instr1, grant1, busy1, timeout1;
   logic [31:0] m0_rdata1, m1_rdata1, s_addr1, s_wdata1;
   logic [3:0]  s_wstrb1;

   picorv32_mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(4)) dut0 (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_valid_i(m0_valid), .m0_instr_i(m0_instr), .m0_addr_i(m0_addr),
      .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb), .m0_ready_o(m0_ready0), .m0_rdata_o(m0_rdata0),
      .m1_valid_i(m1_valid), .m1_instr_i(m1_instr), .m1_addr_i(m1_addr),
      .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb), .m1_ready_o(m1_ready0), .m1_rdata_o(m1_rdata0),
      .s_valid_o(s_valid0), .s_instr_o(s_instr0), .s_addr_o(s_addr0), .s_wdata_o(s_wdata0),
      .s_wstrb_o(s_wstrb0), .s_ready_i(s_ready0), .s_rdata_i(s_rdata0),
      .grant_o(grant0), .busy_o(busy0), .timeout_o(timeout0)
   );

   picorv32_mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(4)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_valid_i(m0_valid), .m0_instr_i(m0_instr), .m0_addr_i(m0_addr),
      .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb), .m0_ready_o(m0_ready1), .m0_rdata_o(m0_rdata1),
      .m1_valid_i(m1_valid), .m1_instr_i(m1_instr), .m1_addr_i(m1_addr),
      .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb), .m1_ready_o(m1_ready1), .m1_rdata_o(m1_rdata1),
      .s_valid_o(s_valid1), .s_instr_o(s_instr1), .s_addr_o(s_addr1), .s_wdata_o(s_wdata1),
      .s_wstrb_o(s_wstrb1), .s_ready_i(s_ready1), .s_rdata_i(s_rdata1),
      .grant_o(grant1), .busy_o(busy1), .timeout_o(timeout1)
   );

   typedef struct {
      logic        m;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          waitc;
      logic        respond;
      logic [31:0] srdata;
      logic [31:0] exp_rdata;
      logic        exp_to;
   } vec_t;

   typedef struct {
      logic        m;
      logic [31:0] rdata;
      logic        to;
   } exp_t;

   exp_t sbq[$];
   int   nvec = 0;
   int   nerr = 0;
   int   cyc = 0;
   int   last_rdy = -1;
   logic phase = 1'b0;
   int   d1_m0_cnt = 0;
   int   d1_m1_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic m, input logic [31:0] rdata, input logic to);
      exp_t e;
      e.m = m;
      e.rdata = rdata;
      e.to = to;
      sbq.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Response scoreboard and slave-side owner checks, sampled mid-cycle.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (m0_ready0 || m1_ready0 || timeout0) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_resp", 32'(1), 32'(0));
         end else begin
            e = sbq.pop_front();
            chk("sb_owner", 32'(m1_ready0), 32'(e.m));
            chk("sb_both_ready", 32'(m0_ready0 && m1_ready0), 32'(0));
            chk("sb_rdata", e.m ? m1_rdata0 : m0_rdata0, e.rdata);
            chk("sb_timeout", 32'(timeout0), 32'(e.to));
         end
         if (phase) begin
            if (last_rdy >= 0) chk("ready_spacing", 32'(cyc - last_rdy), 32'(3));
            last_rdy = cyc;
         end
      end
      if (s_valid0) begin
         chk("s_addr_owner", s_addr0, grant0 ? m1_addr : m0_addr);
         chk("s_wdata_owner", s_wdata0, grant0 ? m1_wdata : m0_wdata);
         chk("s_wstrb_owner", 32'(s_wstrb0), 32'(grant0 ? m1_wstrb : m0_wstrb));
      end
      if (phase) begin
         if (m0_ready1) d1_m0_cnt++;
         if (m1_ready1) d1_m1_cnt++;
         if (busy1) chk("prio_grant", 32'(grant1), 32'(0));
         if (s_valid1) begin
            chk("prio_s_addr", s_addr1, m0_addr);
            chk("prio_s_attr", {s_wdata1[27:0], s_wstrb1}, {m0_wdata[27:0], m0_wstrb});
            chk("prio_s_instr", 32'(s_instr1), 32'(m0_instr));
         end
         chk("prio_no_timeout", 32'(timeout1), 32'(0));
         if (m0_ready1) chk("prio_rdata", m0_rdata1, 32'h600D_0000);
      end
   end

   task automatic run_vec(input vec_t v);
      push_exp(v.m, v.exp_rdata, v.exp_to);
      if (!v.m) begin
         m0_valid = 1; m0_instr = v.instr; m0_addr = v.addr; m0_wdata = v.wdata; m0_wstrb = v.wstrb;
      end else begin
         m1_valid = 1; m1_instr = v.instr; m1_addr = v.addr; m1_wdata = v.wdata; m1_wstrb = v.wstrb;
      end
      s_ready0 = 0;
      s_rdata0 = v.srdata;
      chk("s_valid_idle", 32'(s_valid0), 32'(0));
      tick();
      chk("s_valid_latency", 32'(s_valid0), 32'(1));
      chk("grant", 32'(grant0), 32'(v.m));
      chk("busy_req", 32'(busy0), 32'(1));
      chk("s_addr", s_addr0, v.addr);
      chk("s_wstrb", 32'(s_wstrb0), 32'(v.wstrb));
      chk("s_instr", 32'(s_instr0), 32'(v.instr));
      for (int i = 0; i < v.waitc; i++) begin
         chk("no_early_ready", 32'(m0_ready0 | m1_ready0 | timeout0), 32'(0));
         tick();
      end
      if (v.respond) begin
         s_ready0 = 1;
         tick();
         s_ready0 = 0;
      end
      chk("resp_ready", 32'(v.m ? m1_ready0 : m0_ready0), 32'(1));
      chk("resp_other_ready", 32'(v.m ? m0_ready0 : m1_ready0), 32'(0));
      chk("resp_timeout", 32'(timeout0), 32'(v.exp_to));
      chk("resp_s_valid", 32'(s_valid0), 32'(0));
      m0_valid = 0;
      m1_valid = 0;
      tick();
      chk("idle_busy", 32'(busy0), 32'(0));
      chk("idle_ready", 32'(m0_ready0 | m1_ready0 | timeout0), 32'(0));
      chk("rdata_hold", v.m ? m1_rdata0 : m0_rdata0, v.exp_rdata);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{m:1'b0, instr:1'b0, addr:32'h0000_0100, wdata:32'h0, wstrb:4'h0, waitc:2,
                  respond:1'b1, srdata:32'hCAFE_F00D, exp_rdata:32'hCAFE_F00D, exp_to:1'b0};
      vecs[1] = '{m:1'b1, instr:1'b0, addr:32'h1000_0000, wdata:32'h5, wstrb:4'hF, waitc:4,
                  respond:1'b0, srdata:32'h1234_5678, exp_rdata:32'h0010_0073, exp_to:1'b1};
      vecs[2] = '{m:1'b0, instr:1'b0, addr:32'h0000_0200, wdata:32'h0, wstrb:4'h0, waitc:3,
                  respond:1'b1, srdata:32'h1111_2222, exp_rdata:32'h1111_2222, exp_to:1'b0};
      vecs[3] = '{m:1'b1, instr:1'b1, addr:32'h0000_2000, wdata:32'h0, wstrb:4'h0, waitc:0,
                  respond:1'b1, srdata:32'hDEAD_BEEF, exp_rdata:32'hDEAD_BEEF, exp_to:1'b0};
      vecs[4] = '{m:1'b0, instr:1'b0, addr:32'h0000_0044, wdata:32'h0000_AB00, wstrb:4'b0010, waitc:1,
                  respond:1'b1, srdata:32'h0000_0077, exp_rdata:32'h0000_0077, exp_to:1'b0};
      vecs[5] = '{m:1'b0, instr:1'b1, addr:32'h0000_0300, wdata:32'h0, wstrb:4'h0, waitc:4,
                  respond:1'b0, srdata:32'h0, exp_rdata:32'h0010_0073, exp_to:1'b1};

      repeat (2) tick();
      chk("rst_s_valid", 32'(s_valid0), 32'(0));
      chk("rst_s_addr", s_addr0, 32'h0);
      chk("rst_s_wstrb", 32'(s_wstrb0), 32'(0));
      chk("rst_grant", 32'(grant0), 32'(0));
      chk("rst_busy", 32'(busy0), 32'(0));
      chk("rst_timeout", 32'(timeout0), 32'(0));
      chk("rst_ready", 32'(m0_ready0 | m1_ready0), 32'(0));
      chk("rst_rdata", m0_rdata0 | m1_rdata0, 32'h0);
      rst_n = 1;
      tick();

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Reset mid-REQ after an m0 grant; the pending tie must then go to m0 again.
      m0_valid = 1; m0_instr = 0; m0_addr = 32'h0000_0300; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      s_ready0 = 0;
      tick();
      chk("abort_req_entered", 32'(s_valid0), 32'(1));
      #2;
      m1_valid = 1; m1_instr = 0; m1_addr = 32'h0000_0400; m1_wdata = 32'h0000_ABCD; m1_wstrb = 4'h3;
      rst_n = 0;
      #1;
      chk("async_rst_s_valid", 32'(s_valid0), 32'(0));
      chk("async_rst_busy", 32'(busy0), 32'(0));
      chk("async_rst_ready", 32'(m0_ready0 | m1_ready0), 32'(0));
      chk("async_rst_s_valid_d1", 32'(s_valid1), 32'(0));
      tick();
      tick();

      // Continuous requests from both masters through a zero-wait slave.
      s_ready0 = 1;
      s_rdata0 = 32'h600D_0000;
      push_exp(1'b0, 32'h600D_0000, 1'b0);
      push_exp(1'b1, 32'h600D_0000, 1'b0);
      push_exp(1'b0, 32'h600D_0000, 1'b0);
      push_exp(1'b1, 32'h600D_0000, 1'b0);
      phase = 1;
      rst_n = 1;
      tick();
      chk("tie_after_rst_grant", 32'(grant0), 32'(0));
      chk("tie_after_rst_valid", 32'(s_valid0), 32'(1));
      repeat (11) tick();
      m0_valid = 0;
      m1_valid = 0;
      tick();
      phase = 0;
      s_ready0 = 0;
      repeat (3) tick();

      chk("sb_drained", 32'(sbq.size()), 32'(0));
      chk("prio_m0_serviced", 32'(d1_m0_cnt), 32'(4));
      chk("prio_m1_starved", 32'(d1_m1_cnt), 32'(0));
      chk("prio_m1_rdata_untouched", m1_rdata1, 32'h0);
      chk("final_busy", 32'(busy0 | busy1), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
